// File: rtl/pixel_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pack_fifo
// Description : Packs an even/odd pixel pair (2 x RGB888) into one 48-bit beat.
//               Stores the beat in a DEPTH-entry FIFO together with
//               end-of-row and end-of-frame tags derived from frame geometry.
//               A small frame FSM tracks one frame at a time:
//               IDLE -> ACTIVE -> DRAIN -> DONE -> IDLE.
// Ports       : HCLK, HRESET         clock, synchronous active-high reset
//               HSYNC, DATA_*0/1     input beat valid + even/odd pixel
//               m_valid/m_ready      output handshake
//               m_data/m_eol/m_eof   head beat and its row/frame tags
//               fifo_level           occupied entries, 0..DEPTH
//               overflow             sticky "an input beat was dropped"
//               frame_done           one-cycle pulse once a frame has drained
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_pack_fifo #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [47:0]       m_data,
  output logic              m_eol,
  output logic              m_eof,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              frame_done
);

  localparam int BEATS = WIDTH / 2;
  localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LVL_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [49:0]        mem [DEPTH];   // {eof, eol, pixel pair}
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [COL_W-1:0]   in_col;
  logic [ROW_W-1:0]   in_row;

  logic               accepting;
  logic               pop;
  logic               push;
  logic               full;
  logic               tag_eol;
  logic               tag_eof;
  logic [LVL_W-1:0]   level_next;
  logic [47:0]        pixel_pair;
  logic [49:0]        head;

  assign pixel_pair = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};

  assign accepting = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign full      = (fifo_level == LVL_W'(DEPTH));
  assign pop       = m_valid && m_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push      = accepting && HSYNC && (!full || pop);

  assign tag_eol   = (in_col == COL_W'(BEATS - 1));
  assign tag_eof   = tag_eol && (in_row == ROW_W'(HEIGHT - 1));

  always_comb begin
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LVL_W'(1);
    end
  end

  // Outputs come from registered state only; gating with m_valid keeps the
  // uncleared storage invisible after reset.
  assign head    = mem[rd_ptr];
  assign m_valid = (fifo_level != '0);
  assign m_data  = m_valid ? head[47:0] : 48'd0;
  assign m_eol   = m_valid && head[48];
  assign m_eof   = m_valid && head[49];

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge HCLK) begin
    if (!HRESET && push) begin
      mem[wr_ptr] <= {tag_eof, tag_eol, pixel_pair};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_col     <= '0;
      in_row     <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_level <= level_next;
      frame_done <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      // Covers both a full FIFO while accepting and any beat after the frame
      // end while the frame is still draining.
      if (HSYNC && !push) begin
        overflow <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_ACTIVE: begin
          if (HSYNC) begin
            // Geometry advances even for dropped beats so tags stay aligned.
            if (tag_eol) begin
              in_col <= '0;
              in_row <= tag_eof ? '0 : in_row + ROW_W'(1);
            end else begin
              in_col <= in_col + COL_W'(1);
            end
            state <= tag_eof ? ST_DRAIN : ST_ACTIVE;
          end
        end
        ST_DRAIN: begin
          if (level_next == '0) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          in_col <= '0;
          in_row <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_pack_fifo
// Description : Self-checking bench for pixel_pack_fifo (4x2 frame, 4 entries)
//               plus a 4x4-frame instance for the full-FIFO push+pop case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_pack_fifo;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;
  localparam int A = 2;
  localparam int BPR = W / 2;        // beats per row
  localparam int BPF = BPR * H;      // beats per frame

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync;
  logic        ready;
  logic [47:0] din;

  logic        m_valid, m_eol, m_eof, overflow, frame_done;
  logic [47:0] m_data;
  logic [A:0]  fifo_level;

  logic        m_valid2, m_eol2, m_eof2, overflow2, frame_done2;
  logic [47:0] m_data2;
  logic [A:0]  fifo_level2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_pack_fifo #(.WIDTH(W), .HEIGHT(H), .DEPTH(D), .ADDR_W(A)) u_dut (
    .HCLK(clk), .HRESET(rst), .HSYNC(hsync),
    .DATA_R0(din[23:16]), .DATA_G0(din[15:8]), .DATA_B0(din[7:0]),
    .DATA_R1(din[47:40]), .DATA_G1(din[39:32]), .DATA_B1(din[31:24]),
    .m_valid(m_valid), .m_ready(ready), .m_data(m_data),
    .m_eol(m_eol), .m_eof(m_eof), .fifo_level(fifo_level),
    .overflow(overflow), .frame_done(frame_done)
  );

  // Taller frame so the FIFO can be full while the frame is still active.
  pixel_pack_fifo #(.WIDTH(W), .HEIGHT(4), .DEPTH(D), .ADDR_W(A)) u_dut2 (
    .HCLK(clk), .HRESET(rst), .HSYNC(hsync),
    .DATA_R0(din[23:16]), .DATA_G0(din[15:8]), .DATA_B0(din[7:0]),
    .DATA_R1(din[47:40]), .DATA_G1(din[39:32]), .DATA_B1(din[31:24]),
    .m_valid(m_valid2), .m_ready(ready), .m_data(m_data2),
    .m_eol(m_eol2), .m_eof(m_eof2), .fifo_level(fifo_level2),
    .overflow(overflow2), .frame_done(frame_done2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input bit r, input bit hs, input bit rdy, input logic [47:0] d);
    rst   = r;
    hsync = hs;
    ready = rdy;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] pat(input int i);
    return 48'hA0B0C0D0E000 + 48'(i);
  endfunction

  // ---------------- behavioural reference model (4x2 frame) ----------------
  typedef struct packed {
    logic [47:0] d;
    logic        eol;
    logic        eof;
  } beat_t;

  beat_t q[$];
  int    beat_idx;     // position of next input beat within the frame
  int    phase;        // 0 taking beats, 1 waiting for empty, 2 frame finished
  bit    mdl_ovf;
  bit    mdl_fd;

  task automatic model_reset();
    q.delete();
    beat_idx = 0;
    phase    = 0;
    mdl_ovf  = 0;
    mdl_fd   = 0;
  endtask

  task automatic model_step(input bit hs, input bit rdy, input logic [47:0] d);
    int    sz;
    bit    popd;
    beat_t b;
    sz     = q.size();
    popd   = (sz > 0) && rdy;
    mdl_fd = 0;
    if (popd) void'(q.pop_front());
    case (phase)
      0: if (hs) begin
        b.d   = d;
        b.eol = ((beat_idx % BPR) == BPR - 1);
        b.eof = (beat_idx == BPF - 1);
        if (sz < D || popd) q.push_back(b);
        else mdl_ovf = 1;
        beat_idx++;
        if (b.eof) begin
          beat_idx = 0;
          phase    = 1;
        end
      end
      1: begin
        if (hs) mdl_ovf = 1;
        if (q.size() == 0) begin
          phase  = 2;
          mdl_fd = 1;
        end
      end
      default: begin
        if (hs) mdl_ovf = 1;
        phase    = 0;
        beat_idx = 0;
      end
    endcase
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit          hs;
    bit          rdy;
    logic [47:0] d;
    bit          ev;
    int          elevel;
    logic [47:0] edata;
    bit          eeol;
    bit          eeof;
    bit          edone;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [63:0] rnd;
    bit          r_rst, r_hs, r_rdy;
    int          rprob;

    rst = 1'b1; hsync = 1'b0; ready = 1'b0; din = '0;

    // Four-beat frame streamed with m_ready=1, then a lone beat of a new frame.
    tbl[0] = '{1, 1, pat(0),  1, 1, pat(0),  0, 0, 0};
    tbl[1] = '{1, 1, pat(1),  1, 1, pat(1),  1, 0, 0};
    tbl[2] = '{1, 1, pat(2),  1, 1, pat(2),  0, 0, 0};
    tbl[3] = '{1, 1, pat(3),  1, 1, pat(3),  1, 1, 0};
    tbl[4] = '{0, 1, 48'd0,   0, 0, 48'd0,   0, 0, 1};
    tbl[5] = '{0, 1, 48'd0,   0, 0, 48'd0,   0, 0, 0};
    tbl[6] = '{1, 1, 48'h445566112233, 1, 1, 48'h445566112233, 0, 0, 0};

    // Reset state
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    chk("rst_valid", 64'(m_valid), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_data",  64'(m_data), 0);
    chk("rst_eol",   64'(m_eol), 0);
    chk("rst_eof",   64'(m_eof), 0);
    chk("rst_ovf",   64'(overflow), 0);
    chk("rst_done",  64'(frame_done), 0);

    cyc(1, 0, 0, '0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, tbl[i].hs, tbl[i].rdy, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 64'(m_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].elevel));
      chk($sformatf("tbl%0d_done", i),  64'(frame_done), 64'(tbl[i].edone));
      chk($sformatf("tbl%0d_ovf", i),   64'(overflow), 0);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 64'(m_data), 64'(tbl[i].edata));
        chk($sformatf("tbl%0d_eol", i),  64'(m_eol), 64'(tbl[i].eeol));
        chk($sformatf("tbl%0d_eof", i),  64'(m_eof), 64'(tbl[i].eeof));
      end
    end

    // Stalled output: five beats, fifth arrives after the frame end
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, pat(10 + i));
    chk("stall_level4", 64'(fifo_level), 4);
    chk("stall_ovf0",   64'(overflow), 0);
    cyc(0, 1, 0, pat(14));
    chk("drain_level", 64'(fifo_level), 4);
    chk("drain_ovf",   64'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_data%0d", i), 64'(m_data), 64'(pat(10 + i)));
      chk($sformatf("stall_eol%0d", i),  64'(m_eol), 64'(i % 2 == 1));
      chk($sformatf("stall_eof%0d", i),  64'(m_eof), 64'(i == 3));
      cyc(0, 0, 1, '0);
    end
    chk("stall_empty", 64'(fifo_level), 0);
    chk("stall_done",  64'(frame_done), 1);
    cyc(0, 0, 1, '0);
    chk("stall_done_pulse", 64'(frame_done), 0);
    chk("stall_ovf_sticky", 64'(overflow), 1);

    // Full FIFO with simultaneous push and pop (taller-frame instance)
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, pat(20 + i));
    chk("full_level", 64'(fifo_level2), 4);
    cyc(0, 1, 1, pat(24));
    chk("pp_level", 64'(fifo_level2), 4);
    chk("pp_ovf",   64'(overflow2), 0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("pp_data%0d", i), 64'(m_data2), 64'(pat(20 + i)));
      cyc(0, 0, 1, '0);
    end
    chk("pp_empty", 64'(fifo_level2), 0);

    // Reset mid-frame
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, pat(30));
    cyc(0, 1, 0, pat(31));
    chk("mid_level2", 64'(fifo_level), 2);
    cyc(1, 0, 0, '0);
    chk("mid_rst_valid", 64'(m_valid), 0);
    chk("mid_rst_level", 64'(fifo_level), 0);
    chk("mid_rst_ovf",   64'(overflow), 0);
    cyc(0, 1, 0, pat(32));
    cyc(0, 1, 0, pat(33));
    chk("mid_eol_first", 64'(m_eol), 0);
    cyc(0, 0, 1, '0);
    chk("mid_data_second", 64'(m_data), 64'(pat(33)));
    chk("mid_eol_second",  64'(m_eol), 1);

    // Randomized traffic against the reference model
    cyc(1, 0, 0, '0);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rprob = ((i / 300) % 2 == 1) ? 85 : 30;
      r_rst = ($urandom_range(399) == 0);
      r_hs  = ($urandom_range(99) < 60);
      r_rdy = ($urandom_range(99) < rprob);
      rnd   = {$urandom, $urandom};
      cyc(r_rst, r_hs, r_rdy, rnd[47:0]);
      if (r_rst) model_reset();
      else       model_step(r_hs, r_rdy, rnd[47:0]);
      chk("rnd_valid", 64'(m_valid), 64'(q.size() != 0));
      chk("rnd_level", 64'(fifo_level), 64'(q.size()));
      chk("rnd_ovf",   64'(overflow), 64'(mdl_ovf));
      chk("rnd_done",  64'(frame_done), 64'(mdl_fd));
      if (q.size() != 0) begin
        chk("rnd_data", 64'(m_data), 64'(q[0].d));
        chk("rnd_eol",  64'(m_eol), 64'(q[0].eol));
        chk("rnd_eof",  64'(m_eof), 64'(q[0].eof));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
